// File: rtl/cpu_pkg.sv
// Datapath-wide constants shared by the control unit, ALU and call stack,
// plus the packed layout of one saved return context.
package cpu_pkg;

  localparam int PC_WIDTH    = 9;
  localparam int FLAGS_WIDTH = 4;
  localparam int STACK_DEPTH = 8;

  // ALU flag bit positions inside a FLAGS_WIDTH flag word
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam int STACK_ENTRY_WIDTH = FLAGS_WIDTH + PC_WIDTH;

  typedef struct packed {
    logic [FLAGS_WIDTH-1:0] flags;
    logic [PC_WIDTH-1:0]    pc;
  } stack_entry_t;

  function automatic stack_entry_t make_entry(input logic [FLAGS_WIDTH-1:0] flags,
                                              input logic [PC_WIDTH-1:0]    pc);
    stack_entry_t e;
    e.flags = flags;
    e.pc    = pc;
    return e;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Register file holding the saved contexts: one synchronous write port and
// one asynchronous read port. Contents are deliberately left unreset.
module stack_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return stack: saves {flags, pc} on call and restores it on return.
// Owns the stack pointer, the registered pop outputs and the sticky error flags.
module call_stack #(
  parameter int DEPTH       = cpu_pkg::STACK_DEPTH,
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int FLAGS_WIDTH = cpu_pkg::FLAGS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_push_en,
  input  logic                     in_pop_en,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [FLAGS_WIDTH-1:0]   in_flags,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [FLAGS_WIDTH-1:0]   out_flags,
  output logic [$clog2(DEPTH):0]   out_depth,
  output logic                     out_empty,
  output logic                     out_full,
  output logic                     out_overflow,
  output logic                     out_underflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam int EW  = FLAGS_WIDTH + PC_WIDTH;

  logic [SPW-1:0]         r_sp;
  logic [PC_WIDTH-1:0]    r_out_pc;
  logic [FLAGS_WIDTH-1:0] r_out_flags;
  logic                   r_overflow;
  logic                   r_underflow;

  logic [SPW-1:0] w_sp_dec;
  logic           w_empty;
  logic           w_full;
  logic           w_pop_ok;
  logic           w_push_ok;
  logic [AW-1:0]  w_rd_addr;
  logic [AW-1:0]  w_wr_addr;
  logic [EW-1:0]  w_wdata;
  logic [EW-1:0]  w_rdata;

  assign w_sp_dec  = r_sp - SPW'(1);
  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SPW'(DEPTH));
  assign w_pop_ok  = in_pop_en && !w_empty;
  // A push into a full stack is still fine when a pop frees the top slot first
  assign w_push_ok = in_push_en && (!w_full || w_pop_ok);
  assign w_rd_addr = w_sp_dec[AW-1:0];
  assign w_wr_addr = w_pop_ok ? w_sp_dec[AW-1:0] : r_sp[AW-1:0];
  assign w_wdata   = {in_flags, in_pc};

  stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_stack_mem (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_out_pc    <= '0;
      r_out_flags <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        {r_out_flags, r_out_pc} <= w_rdata;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_sp <= r_sp + SPW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
        r_sp <= w_sp_dec;
      end
      if (in_push_en && !in_pop_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (in_pop_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign out_pc        = r_out_pc;
  assign out_flags     = r_out_flags;
  assign out_depth     = r_sp;
  assign out_empty     = w_empty;
  assign out_full      = w_full;
  assign out_overflow  = r_overflow;
  assign out_underflow = r_underflow;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: a queue-based LIFO model is checked against
// the DUT every cycle, plus literal expectations from hand-worked scenarios.
module tb_call_stack;

  localparam int DEPTH = 8;
  localparam int PCW   = 9;
  localparam int FW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_push_en = 1'b0;
  logic          in_pop_en = 1'b0;
  logic [PCW-1:0] in_pc = '0;
  logic [FW-1:0]  in_flags = '0;
  logic [PCW-1:0] out_pc;
  logic [FW-1:0]  out_flags;
  logic [3:0]     out_depth;
  logic           out_empty, out_full, out_overflow, out_underflow;

  int checks = 0;
  int failures = 0;

  // Behavioural model
  logic [FW+PCW-1:0] m_stk[$];
  logic [PCW-1:0]    m_pc = '0;
  logic [FW-1:0]     m_flags = '0;
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  logic              chk_en = 1'b0;

  call_stack #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .FLAGS_WIDTH(FW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_push_en    (in_push_en),
    .in_pop_en     (in_pop_en),
    .in_pc         (in_pc),
    .in_flags      (in_flags),
    .out_pc        (out_pc),
    .out_flags     (out_flags),
    .out_depth     (out_depth),
    .out_empty     (out_empty),
    .out_full      (out_full),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_pc = '0;
    m_flags = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic push, input logic pop,
                            input logic [PCW-1:0] pc, input logic [FW-1:0] fl);
    logic [FW+PCW-1:0] v;
    if (push && pop) begin
      if (m_stk.size() == 0) begin
        m_unf = 1'b1;
        m_stk.push_back({fl, pc});
      end else begin
        v = m_stk.pop_back();
        {m_flags, m_pc} = v;
        m_stk.push_back({fl, pc});
      end
    end else if (push) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back({fl, pc});
    end else if (pop) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else begin
        v = m_stk.pop_back();
        {m_flags, m_pc} = v;
      end
    end
  endtask

  // One operation: drive after a falling edge, apply at the rising edge,
  // return #1 after it with the model updated.
  task automatic op(input logic push, input logic pop,
                    input logic [PCW-1:0] pc, input logic [FW-1:0] fl);
    @(negedge clk);
    in_push_en = push;
    in_pop_en  = pop;
    in_pc      = pc;
    in_flags   = fl;
    @(posedge clk);
    #1;
    model_step(push, pop, pc, fl);
    in_push_en = 1'b0;
    in_pop_en  = 1'b0;
    $display("op push=%0b pop=%0b pc=%0h flags=%0h -> out_pc=%0h out_flags=%0h depth=%0d",
             push, pop, pc, fl, out_pc, out_flags, out_depth);
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("depth",     int'(out_depth),     m_stk.size());
      check("empty",     int'(out_empty),     int'(m_stk.size() == 0));
      check("full",      int'(out_full),      int'(m_stk.size() == DEPTH));
      check("overflow",  int'(out_overflow),  int'(m_ovf));
      check("underflow", int'(out_underflow), int'(m_unf));
      check("out_pc",    int'(out_pc),        int'(m_pc));
      check("out_flags", int'(out_flags),     int'(m_flags));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_depth", int'(out_depth), 0);
    check("rst_empty", int'(out_empty), 1);
    check("rst_full",  int'(out_full), 0);
    check("rst_pc",    int'(out_pc), 0);
    check("rst_ovf",   int'(out_overflow), 0);
    check("rst_unf",   int'(out_underflow), 0);
    chk_en = 1'b1;

    // Call / return
    op(1, 0, 9'h1E1, 4'b1001);
    op(0, 1, 9'h000, 4'b0000);
    check("cr_pc",    int'(out_pc), 'h1E1);
    check("cr_flags", int'(out_flags), 'b1001);
    check("cr_empty", int'(out_empty), 1);

    // LIFO order
    for (int i = 1; i <= 3; i++) op(1, 0, 9'(i), 4'(i));
    check("lifo_depth3", int'(out_depth), 3);
    for (int i = 3; i >= 1; i--) begin
      op(0, 1, 9'h0, 4'h0);
      check("lifo_pc",    int'(out_pc), i);
      check("lifo_flags", int'(out_flags), i);
      check("lifo_depth", int'(out_depth), i - 1);
    end

    // Underflow: outputs hold the last popped value (pc=1)
    op(0, 1, 9'h0, 4'h0);
    check("unf_flag",  int'(out_underflow), 1);
    check("unf_pc",    int'(out_pc), 1);
    check("unf_depth", int'(out_depth), 0);
    op(1, 0, 9'h055, 4'h5);
    op(0, 1, 9'h0, 4'h0);
    check("unf_sticky", int'(out_underflow), 1);
    check("unf_pc2",    int'(out_pc), 'h55);

    // Simultaneous push/pop on empty: plain push plus underflow
    op(1, 1, 9'h0AA, 4'hA);
    check("sim_empty_depth", int'(out_depth), 1);
    check("sim_empty_pc",    int'(out_pc), 'h55);
    op(0, 1, 9'h0, 4'h0);
    check("sim_empty_pop",   int'(out_pc), 'hAA);

    // Asynchronous reset mid-cycle with depth 3
    for (int i = 0; i < 3; i++) op(1, 0, 9'(i + 'h10), 4'(i));
    check("pre_rst_depth", int'(out_depth), 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_depth", int'(out_depth), 0);
    check("arst_empty", int'(out_empty), 1);
    check("arst_pc",    int'(out_pc), 0);
    check("arst_flags", int'(out_flags), 0);
    check("arst_unf",   int'(out_underflow), 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Full and overflow: nine pushes, value 8 is dropped
    for (int i = 0; i <= DEPTH; i++) op(1, 0, 9'(i), 4'(i));
    check("full_flag",  int'(out_full), 1);
    check("ovf_flag",   int'(out_overflow), 1);
    check("full_depth", int'(out_depth), 8);

    // Simultaneous while full: pop-then-push, depth stays 8
    op(1, 1, 9'h1FF, 4'hF);
    check("sim_full_pc",    int'(out_pc), 7);
    check("sim_full_depth", int'(out_depth), 8);
    op(0, 1, 9'h0, 4'h0);
    check("sim_full_pop",   int'(out_pc), 'h1FF);
    op(1, 0, 9'h007, 4'h7);
    for (int i = 7; i >= 0; i--) begin
      op(0, 1, 9'h0, 4'h0);
      check("drain_pc", int'(out_pc), i);
    end
    check("drain_empty", int'(out_empty), 1);
    check("ovf_sticky",  int'(out_overflow), 1);

    // Simultaneous with one entry: returns 5, then 9
    op(1, 0, 9'h005, 4'h3);
    op(1, 1, 9'h009, 4'h6);
    check("sim_pc",    int'(out_pc), 5);
    check("sim_depth", int'(out_depth), 1);
    op(0, 1, 9'h0, 4'h0);
    check("sim_pop_pc",    int'(out_pc), 9);
    check("sim_pop_flags", int'(out_flags), 6);

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
